// File: rtl/spike_rate_decoder_if.sv
// Readout stream of the spike rate decoder: one channel count per beat, valid/ready.
interface spike_rate_decoder_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned CNT_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_ch;
    logic [CNT_W-1:0] count_out;
    logic             count_sat;
    logic             out_last;

    modport master (
        output out_valid,
        output out_ch,
        output count_out,
        output count_sat,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_ch,
        input  count_out,
        input  count_sat,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes per channel over a programmable window,
// snapshots the counts at window end and streams them out one channel per beat.
module spike_rate_decoder #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned WINDOW_W = 10,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned CH_W     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [WINDOW_W-1:0] window_len,
    input  logic [N_CH-1:0]     spike_in,
    spike_rate_decoder_if.master out_if,
    output logic [7:0]          drop_cnt
);

    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic {IDLE, COUNT} cnt_state_t;
    typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

    cnt_state_t          cnt_state;
    rd_state_t           rd_state;

    // Live window counters
    logic [CNT_W-1:0]    cnt_q [N_CH];
    logic [N_CH-1:0]     sat_q;
    logic [WINDOW_W-1:0] t_q;
    logic [WINDOW_W-1:0] len_q;

    // Snapshot held while it is being streamed out
    logic [CNT_W-1:0]    sh_cnt [N_CH];
    logic [N_CH-1:0]     sh_sat;

    // Registered output beat
    logic                valid_q;
    logic [CH_W-1:0]     ch_q;
    logic [CNT_W-1:0]    count_q;
    logic                cs_q;
    logic                last_q;

    logic [WINDOW_W-1:0] len_eff_c;
    logic [SUM_W-1:0]    sum_c [N_CH];
    logic [CNT_W-1:0]    cnt_nxt_c [N_CH];
    logic [N_CH-1:0]     sat_nxt_c;
    logic                win_end_c;
    logic                snap_req_c;
    logic                xfer_c;
    logic                load_c;
    logic [CH_W-1:0]     ch_nxt_c;

    // Saturating next counts, window-end detection and readout load decision
    always_comb begin
        len_eff_c  = len_q;
        sat_nxt_c  = '0;
        for (int i = 0; i < N_CH; i++) begin
            sum_c[i]     = '0;
            cnt_nxt_c[i] = '0;
        end

        // Length is taken from window_len on the first cycle of each window; 0 means 1
        if (t_q == '0) begin
            len_eff_c = (window_len == '0) ? WINDOW_W'(1) : window_len;
        end

        for (int i = 0; i < N_CH; i++) begin
            sum_c[i]     = {1'b0, cnt_q[i]} + SUM_W'(spike_in[i]);
            cnt_nxt_c[i] = sum_c[i][CNT_W] ? {CNT_W{1'b1}} : sum_c[i][CNT_W-1:0];
            sat_nxt_c[i] = sat_q[i] | sum_c[i][CNT_W];
        end

        win_end_c  = (t_q == (len_eff_c - WINDOW_W'(1)));
        snap_req_c = (cnt_state == COUNT) && enable && win_end_c;
        xfer_c     = valid_q && out_if.out_ready;
        load_c     = snap_req_c && ((rd_state == RD_IDLE) || (xfer_c && last_q));
        ch_nxt_c   = ch_q + CH_W'(1);
    end

    // Counting FSM: live counters, window timer and latched window length
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_state <= IDLE;
            t_q       <= '0;
            len_q     <= '0;
            sat_q     <= '0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            case (cnt_state)
                IDLE: begin
                    t_q   <= '0;
                    sat_q <= '0;
                    for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
                    if (enable) cnt_state <= COUNT;
                end
                COUNT: begin
                    if (!enable) begin
                        // Partial window is discarded
                        cnt_state <= IDLE;
                        t_q       <= '0;
                        sat_q     <= '0;
                        for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
                    end else begin
                        if (t_q == '0) len_q <= len_eff_c;
                        if (win_end_c) begin
                            t_q   <= '0;
                            sat_q <= '0;
                            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
                        end else begin
                            t_q   <= t_q + WINDOW_W'(1);
                            sat_q <= sat_nxt_c;
                            for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_nxt_c[i];
                        end
                    end
                end
                default: cnt_state <= IDLE;
            endcase
        end
    end

    // Readout FSM: snapshot load, beat sequencing and drop counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            valid_q  <= 1'b0;
            ch_q     <= '0;
            count_q  <= '0;
            cs_q     <= 1'b0;
            last_q   <= 1'b0;
            sh_sat   <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < N_CH; i++) sh_cnt[i] <= '0;
        end else if (load_c) begin
            rd_state <= RD_SEND;
            valid_q  <= 1'b1;
            ch_q     <= '0;
            count_q  <= cnt_nxt_c[0];
            cs_q     <= sat_nxt_c[0];
            last_q   <= (N_CH == 1);
            sh_sat   <= sat_nxt_c;
            for (int i = 0; i < N_CH; i++) sh_cnt[i] <= cnt_nxt_c[i];
        end else if (rd_state == RD_SEND) begin
            if (xfer_c && last_q) begin
                rd_state <= RD_IDLE;
                valid_q  <= 1'b0;
                ch_q     <= '0;
                count_q  <= '0;
                cs_q     <= 1'b0;
                last_q   <= 1'b0;
            end else if (xfer_c) begin
                ch_q    <= ch_nxt_c;
                count_q <= sh_cnt[ch_nxt_c];
                cs_q    <= sh_sat[ch_nxt_c];
                last_q  <= (ch_nxt_c == CH_W'(N_CH - 1));
            end
            // A window that ends while a dump is still in flight is lost
            if (snap_req_c && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_ch    = ch_q;
    assign out_if.count_out = count_q;
    assign out_if.count_sat = cs_q;
    assign out_if.out_last  = last_q;

endmodule
